// File: rtl/fmps_test_link_pkg.sv
// Shared constants for the FMPS test link: default header layout, status codes
// and receiver FSM encodings, used by both the transmitter and the receiver.
package fmps_test_link_pkg;

    localparam int          DEF_MAGIC_WIDTH     = 16;
    localparam int          DEF_MAGIC_START_BIT = 16;
    localparam int          DEF_INDEX_WIDTH     = 5;
    localparam int          DEF_INDEX_START_BIT = 10;
    localparam logic [15:0] DEF_HEADER_MAGIC    = 16'hB6CF;

    // Wide enough to count up to the largest supported payload (16 beats).
    localparam int          BEAT_COUNT_WIDTH    = 5;

    localparam logic [1:0]  STATUS_OK           = 2'd0;
    localparam logic [1:0]  STATUS_BAD_MAGIC    = 2'd1;
    localparam logic [1:0]  STATUS_SHORT        = 2'd2;
    localparam logic [1:0]  STATUS_LONG         = 2'd3;

    typedef enum logic [1:0] {
        ST_HEADER  = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DRAIN   = 2'd2
    } rxState_t;

    // Header word as the transmitter builds it with the default field layout.
    function automatic logic [31:0] fmpsHeader(input logic [DEF_INDEX_WIDTH-1:0] index);
        return {DEF_HEADER_MAGIC, 16'h0000} | (32'(index) << DEF_INDEX_START_BIT);
    endfunction

endpackage

// File: rtl/read_fmps_test_link_if.sv
// AXI-Stream RX bundle of the FMPS test link; there is no tready, every valid
// beat is consumed by the receiver.
interface read_fmps_test_link_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;

    modport master (output tdata, tvalid, tlast);
    modport slave  (input  tdata, tvalid, tlast);
endinterface

// File: rtl/fmps_rx_cycle_stats.sv
// Per fast-acquisition-cycle packet statistics and the cumulative error count
// of the FMPS test link receiver.
module fmps_rx_cycle_stats
    import fmps_test_link_pkg::*;
#(
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH
) (
    input  logic                      auroraUserClk,
    input  logic                      auroraReset_n,
    input  logic                      auroraFAstrobe,
    input  logic                      packetStrobe,
    input  logic [INDEX_WIDTH-1:0]    packetIndex,
    input  logic                      statusStrobe,
    input  logic [1:0]                statusCode,
    output logic [7:0]                cyclePacketCount,
    output logic [2**INDEX_WIDTH-1:0] cycleIndexMap,
    output logic                      cycleStrobe,
    output logic [15:0]               errorCount
);

    localparam int MAP_WIDTH = 2**INDEX_WIDTH;

    logic [7:0]           runCountReg;
    logic [MAP_WIDTH-1:0] runMapReg;
    logic [MAP_WIDTH-1:0] indexOneHot;

    for (genvar gi = 0; gi < MAP_WIDTH; gi++) begin : gIndexDecode
        assign indexOneHot[gi] = (packetIndex == INDEX_WIDTH'(gi));
    end

    // A packet reported in the same cycle as the FA boundary opens the new cycle.
    always_ff @(posedge auroraUserClk or negedge auroraReset_n) begin
        if (!auroraReset_n) begin
            runCountReg      <= '0;
            runMapReg        <= '0;
            cyclePacketCount <= '0;
            cycleIndexMap    <= '0;
            cycleStrobe      <= 1'b0;
            errorCount       <= '0;
        end else begin
            cycleStrobe <= auroraFAstrobe;
            if (auroraFAstrobe) begin
                cyclePacketCount <= runCountReg;
                cycleIndexMap    <= runMapReg;
                runCountReg      <= packetStrobe ? 8'd1 : 8'd0;
                runMapReg        <= packetStrobe ? indexOneHot : '0;
            end else if (packetStrobe) begin
                runCountReg <= (runCountReg == 8'hFF) ? 8'hFF : runCountReg + 8'd1;
                runMapReg   <= runMapReg | indexOneHot;
            end
            if (statusStrobe && (statusCode != STATUS_OK) && (errorCount != 16'hFFFF)) begin
                errorCount <= errorCount + 16'd1;
            end
        end
    end

endmodule

// File: rtl/read_fmps_test_link.sv
// FMPS test link receiver: parses header + payload packets from the Aurora
// RX stream, reports each packet's status and gathers per-FA-cycle statistics.
module read_fmps_test_link
    import fmps_test_link_pkg::*;
#(
    parameter int                     MAGIC_WIDTH     = DEF_MAGIC_WIDTH,
    parameter int                     MAGIC_START_BIT = DEF_MAGIC_START_BIT,
    parameter int                     INDEX_WIDTH     = DEF_INDEX_WIDTH,
    parameter int                     INDEX_START_BIT = DEF_INDEX_START_BIT,
    parameter int                     NUM_DATA_WORDS  = 1,
    parameter logic [MAGIC_WIDTH-1:0] HEADER_MAGIC    = MAGIC_WIDTH'(DEF_HEADER_MAGIC)
) (
    input  logic                         auroraUserClk,
    input  logic                         auroraReset_n,
    input  logic                         auroraChannelUp,
    input  logic                         auroraFAstrobe,
    read_fmps_test_link_if.slave         FMPS_TEST_AXI_STREAM_RX,
    output logic                         packetStrobe,
    output logic [INDEX_WIDTH-1:0]       packetIndex,
    output logic [32*NUM_DATA_WORDS-1:0] packetData,
    output logic                         statusStrobe,
    output logic [1:0]                   statusCode,
    output logic [7:0]                   cyclePacketCount,
    output logic [2**INDEX_WIDTH-1:0]    cycleIndexMap,
    output logic                         cycleStrobe,
    output logic [15:0]                  errorCount
);

    localparam logic [BEAT_COUNT_WIDTH-1:0] LAST_BEAT = BEAT_COUNT_WIDTH'(NUM_DATA_WORDS - 1);

    rxState_t                     stateReg, stateNext;
    logic [BEAT_COUNT_WIDTH-1:0]  beatCountReg, beatCountNext;
    logic [INDEX_WIDTH-1:0]       indexReg, indexNext;
    logic [32*NUM_DATA_WORDS-1:0] dataBufReg, dataBufNext;
    logic                         wordLoad;
    logic                         packetOkNext;
    logic                         statusFireNext;
    logic [1:0]                   statusCodeNext;

    logic [31:0]            rxData;
    logic                   rxValid;
    logic                   rxLast;
    logic [MAGIC_WIDTH-1:0] hdrMagic;
    logic [INDEX_WIDTH-1:0] hdrIndex;
    logic                   lastBeat;

    assign rxData   = FMPS_TEST_AXI_STREAM_RX.tdata;
    assign rxValid  = FMPS_TEST_AXI_STREAM_RX.tvalid;
    assign rxLast   = FMPS_TEST_AXI_STREAM_RX.tlast;
    assign hdrMagic = rxData[MAGIC_START_BIT +: MAGIC_WIDTH];
    assign hdrIndex = rxData[INDEX_START_BIT +: INDEX_WIDTH];
    assign lastBeat = (beatCountReg == LAST_BEAT);

    // The completing beat goes straight into the assembled word, so the packet
    // data is ready in the same cycle the terminating beat is seen.
    for (genvar gi = 0; gi < NUM_DATA_WORDS; gi++) begin : gPayloadSlot
        assign dataBufNext[gi*32 +: 32] =
            (wordLoad && (beatCountReg == BEAT_COUNT_WIDTH'(gi))) ? rxData : dataBufReg[gi*32 +: 32];
    end

    always_comb begin
        stateNext      = stateReg;
        beatCountNext  = beatCountReg;
        indexNext      = indexReg;
        wordLoad       = 1'b0;
        packetOkNext   = 1'b0;
        statusFireNext = 1'b0;
        statusCodeNext = STATUS_OK;
        if (!auroraChannelUp) begin
            stateNext = ST_HEADER;
        end else if (rxValid) begin
            unique case (stateReg)
                ST_HEADER: begin
                    if (hdrMagic != HEADER_MAGIC) begin
                        statusFireNext = 1'b1;
                        statusCodeNext = STATUS_BAD_MAGIC;
                        stateNext      = rxLast ? ST_HEADER : ST_DRAIN;
                    end else if (rxLast) begin
                        statusFireNext = 1'b1;
                        statusCodeNext = STATUS_SHORT;
                    end else begin
                        indexNext     = hdrIndex;
                        beatCountNext = '0;
                        stateNext     = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    wordLoad      = 1'b1;
                    beatCountNext = beatCountReg + 1'b1;
                    if (rxLast && lastBeat) begin
                        packetOkNext   = 1'b1;
                        statusFireNext = 1'b1;
                        statusCodeNext = STATUS_OK;
                        stateNext      = ST_HEADER;
                    end else if (rxLast) begin
                        statusFireNext = 1'b1;
                        statusCodeNext = STATUS_SHORT;
                        stateNext      = ST_HEADER;
                    end else if (lastBeat) begin
                        statusFireNext = 1'b1;
                        statusCodeNext = STATUS_LONG;
                        stateNext      = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (rxLast) begin
                        stateNext = ST_HEADER;
                    end
                end
                default: stateNext = ST_HEADER;
            endcase
        end
    end

    always_ff @(posedge auroraUserClk or negedge auroraReset_n) begin
        if (!auroraReset_n) begin
            stateReg     <= ST_HEADER;
            beatCountReg <= '0;
            indexReg     <= '0;
            dataBufReg   <= '0;
            packetStrobe <= 1'b0;
            packetIndex  <= '0;
            packetData   <= '0;
            statusStrobe <= 1'b0;
            statusCode   <= STATUS_OK;
        end else begin
            stateReg     <= stateNext;
            beatCountReg <= beatCountNext;
            indexReg     <= indexNext;
            dataBufReg   <= dataBufNext;
            packetStrobe <= packetOkNext;
            statusStrobe <= statusFireNext;
            if (statusFireNext) begin
                statusCode <= statusCodeNext;
            end
            if (packetOkNext) begin
                packetIndex <= indexReg;
                packetData  <= dataBufNext;
            end
        end
    end

    fmps_rx_cycle_stats #(
        .INDEX_WIDTH (INDEX_WIDTH)
    ) uCycleStats (
        .auroraUserClk    (auroraUserClk),
        .auroraReset_n    (auroraReset_n),
        .auroraFAstrobe   (auroraFAstrobe),
        .packetStrobe     (packetStrobe),
        .packetIndex      (packetIndex),
        .statusStrobe     (statusStrobe),
        .statusCode       (statusCode),
        .cyclePacketCount (cyclePacketCount),
        .cycleIndexMap    (cycleIndexMap),
        .cycleStrobe      (cycleStrobe),
        .errorCount       (errorCount)
    );

endmodule
